// File: rtl/fsm_mon_pkg.sv
// Shared types and helpers for the FSM output monitor.
package fsm_mon_pkg;

    typedef enum logic {ARM = 1'b0, RUN = 1'b1} mon_state_e;

    localparam int CODE_W   = 3;
    localparam int EVT_TS_W = 16;

    // Event layout at the default timestamp width; the FIFO stores the same {ts, code} packing for any width.
    typedef struct packed {
        logic [EVT_TS_W-1:0] ts;
        logic [CODE_W-1:0]   code;
    } event_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/fsm_mon_fifo.sv
// Parameterised synchronous FIFO with flush; head entry is presented combinationally from storage.
module fsm_mon_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_wr = push && (!full || pop) && !flush;
    assign do_rd = pop && !empty && !flush;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == FULL_LVL);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fsm_out_monitor.sv
// Logs timestamped changes of the observed 3-bit FSM output code and counts illegal codes and drops.
module fsm_out_monitor
    import fsm_mon_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     out1,
    input  logic                     out2,
    input  logic                     out3,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [2:0]               rd_code,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     armed
);

    localparam int EW = TS_W + CODE_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    mon_state_e      state;
    logic [2:0]      obs;
    logic [2:0]      base;
    logic [TS_W-1:0] ts;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [EW-1:0]   head;

    assign obs  = {out3, out2, out1};
    assign push = (state == RUN) && en && (obs != base) && !clr;
    assign pop  = !empty && rd_ready && !clr;

    fsm_mon_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (push),
        .pop   (pop),
        .din   ({ts, obs}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign rd_valid = !empty;
    assign rd_code  = head[CODE_W-1:0];
    assign rd_ts    = head[EW-1:CODE_W];
    assign armed    = (state == RUN);

    // Free-running timestamp: neither en nor clr interrupts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + TS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARM;
            base     <= 3'b000;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr) begin
            state    <= ARM;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                ARM: begin
                    if (en) begin
                        base  <= obs;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        base <= obs;
                        if (popcount3(obs) > 2'd1) err_cnt <= sat_inc(err_cnt);
                    end
                end
                default: state <= ARM;
            endcase
            if (push && full && !pop) begin
                ovf      <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_fsm_out_monitor.sv
// Directed bench for fsm_out_monitor with immediate-assertion checks.
module tb_fsm_out_monitor;

    localparam int DEPTH = 8;
    localparam int TS_W  = 16;
    localparam int CNT_W = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   en;
    logic                   clr;
    logic                   out1;
    logic                   out2;
    logic                   out3;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [2:0]             rd_code;
    logic [TS_W-1:0]        rd_ts;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;
    logic [CNT_W-1:0]       drop_cnt;
    logic [CNT_W-1:0]       err_cnt;
    logic                   armed;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0;

    fsm_out_monitor #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_code  (rd_code),
        .rd_ts    (rd_ts),
        .level    (level),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .err_cnt  (err_cnt),
        .armed    (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_obs(input logic [2:0] v);
        {out3, out2, out1} = v;
    endtask

    initial begin
        logic [2:0] exp_code [3];
        int         exp_ts   [3];
        exp_code = '{3'b010, 3'b100, 3'b001};
        exp_ts   = '{10, 11, 12};

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        set_obs(3'b000);
        #1;
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_level",    32'(level),    32'd0);
        chk("reset_armed",    32'(armed),    32'd0);
        chk("reset_ovf",      32'(ovf),      32'd0);
        chk("reset_drop",     32'(drop_cnt), 32'd0);
        chk("reset_err",      32'(err_cnt),  32'd0);
        #21;
        rst_n = 1'b1;

        // Arm on 001 and hold: baseline only, no events.
        en = 1'b1;
        set_obs(3'b001);
        step();
        chk("arm_after_en", 32'(armed), 32'd1);
        repeat (4) step();
        chk("arm_level",    32'(level),    32'd0);
        chk("arm_rd_valid", 32'(rd_valid), 32'd0);

        while (cyc < 10) step();
        set_obs(3'b010); step();
        chk("seq_first_valid", 32'(rd_valid), 32'd1);
        set_obs(3'b100); step();
        set_obs(3'b001); step();
        chk("seq_level", 32'(level), 32'd3);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_code", 32'(rd_code), 32'(exp_code[i]));
            chk("seq_ts",   32'(rd_ts),   32'(exp_ts[i]));
            step();
        end
        chk("seq_drained", 32'(level), 32'd0);
        chk("seq_empty",   32'(rd_valid), 32'd0);
        chk("empty_code",  32'(rd_code), 32'd0);
        rd_ready = 1'b0;

        // Overflow: 12 changes into 8 entries.
        t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            set_obs((i % 2 == 0) ? 3'b010 : 3'b001);
            step();
        end
        chk("ovf_level", 32'(level),    32'd8);
        chk("ovf_flag",  32'(ovf),      32'd1);
        chk("ovf_drop",  32'(drop_cnt), 32'd4);
        chk("ovf_head_code", 32'(rd_code), 32'd2);
        chk("ovf_head_ts",   32'(rd_ts),   32'(t0));
        rd_ready = 1'b1;
        set_obs(3'b010); step();
        chk("full_pushpop_level", 32'(level),    32'd8);
        chk("full_pushpop_drop",  32'(drop_cnt), 32'd4);
        chk("full_pushpop_code",  32'(rd_code),  32'd1);
        chk("full_pushpop_ts",    32'(rd_ts),    32'(t0 + 1));
        set_obs(3'b001); step();
        chk("full_pushpop_level2", 32'(level),   32'd8);
        chk("full_pushpop_code2",  32'(rd_code), 32'd2);
        repeat (8) step();
        chk("ovf_drained", 32'(level), 32'd0);
        chk("ovf_sticky",  32'(ovf),   32'd1);
        rd_ready = 1'b0;

        // Illegal code held three cycles: one event, three error counts.
        t0 = cyc;
        set_obs(3'b011);
        repeat (3) step();
        chk("illegal_err",   32'(err_cnt), 32'd3);
        chk("illegal_level", 32'(level),   32'd1);
        chk("illegal_code",  32'(rd_code), 32'd3);
        chk("illegal_ts",    32'(rd_ts),   32'(t0));
        en = 1'b0;
        set_obs(3'b100); step();
        set_obs(3'b010); step();
        chk("en0_level", 32'(level),   32'd1);
        chk("en0_err",   32'(err_cnt), 32'd3);
        chk("en0_armed", 32'(armed),   32'd1);

        // Fill to five then clear alongside an obs change.
        en = 1'b1;
        set_obs(3'b010); step();
        set_obs(3'b001); step();
        set_obs(3'b010); step();
        set_obs(3'b001); step();
        chk("preclr_level", 32'(level), 32'd5);
        clr = 1'b1;
        set_obs(3'b100); step();
        clr = 1'b0;
        chk("clr_level", 32'(level),    32'd0);
        chk("clr_ovf",   32'(ovf),      32'd0);
        chk("clr_drop",  32'(drop_cnt), 32'd0);
        chk("clr_err",   32'(err_cnt),  32'd0);
        chk("clr_armed", 32'(armed),    32'd0);
        step();
        chk("rearm_armed", 32'(armed), 32'd1);
        chk("rearm_level", 32'(level), 32'd0);
        t0 = cyc;
        set_obs(3'b001); step();
        chk("clr_ts_continues", 32'(rd_ts),   32'(t0));
        chk("clr_post_code",    32'(rd_code), 32'd1);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_level",    32'(level),    32'd0);
        chk("async_armed",    32'(armed),    32'd0);
        chk("async_rd_ts",    32'(rd_ts),    32'd0);
        rst_n = 1'b1;
        cyc = 0;
        set_obs(3'b010); step();
        chk("post_rst_armed", 32'(armed), 32'd1);
        chk("post_rst_level", 32'(level), 32'd0);
        set_obs(3'b100); step();
        chk("post_rst_code", 32'(rd_code), 32'd4);
        chk("post_rst_ts",   32'(rd_ts),   32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
